// File: rtl/br_ctrl_pkg.sv
// Shared types for the EX-stage branch redirect controller: FSM state encoding and width defaults.
package br_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLUSH    = 2'd1,
      REDIRECT = 2'd2
   } br_state_e;

   localparam int PC_W_DEF  = 32;
   localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/branch_redirect_ctrl.sv
// Control-hazard sequencer: captures a taken branch target, flushes IF/ID and ID/EX, and holds the
// fetch redirect until accepted. Optional branch statistics are compiled in with BRANCH_STATS_EN.
module branch_redirect_ctrl
   import br_ctrl_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
`ifdef BRANCH_STATS_EN
   ,
   parameter int CNT_W = CNT_W_DEF
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             br_valid,
   input  logic             is_branch_taken,
   input  logic [PC_W-1:0]  branch_pc,
   input  logic             stall_ex,
   input  logic             imem_ready,
`ifdef BRANCH_STATS_EN
   input  logic             stats_clr,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] taken_count,
`endif
   output logic             redirect_valid,
   output logic [PC_W-1:0]  redirect_pc,
   output logic             flush_if,
   output logic             flush_id,
   output logic             hold_fetch,
   output logic             busy
);

   br_state_e       state_q, state_d;
   logic [PC_W-1:0] target_q, target_d;
   logic            accept;
   logic            capture;

   // Branch results are only looked at in IDLE, so squashed shadow instructions never redirect.
   assign accept  = (state_q == IDLE) & br_valid & ~stall_ex;
   assign capture = accept & is_branch_taken;

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      case (state_q)
         IDLE: begin
            if (capture) begin
               state_d  = FLUSH;
               target_d = branch_pc;
            end
         end
         FLUSH:    state_d = imem_ready ? IDLE : REDIRECT;
         REDIRECT: state_d = imem_ready ? IDLE : REDIRECT;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
      end
   end

   assign flush_if       = (state_q == FLUSH);
   assign flush_id       = (state_q == FLUSH);
   assign redirect_valid = (state_q == FLUSH) | (state_q == REDIRECT);
   assign hold_fetch     = redirect_valid;
   assign busy           = (state_q != IDLE);
   assign redirect_pc    = target_q;

`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0] br_count_q, br_count_d;
   logic [CNT_W-1:0] taken_count_q, taken_count_d;

   // Clear wins over a same-cycle increment; counters wrap naturally.
   always_comb begin
      br_count_d    = br_count_q;
      taken_count_d = taken_count_q;
      if (stats_clr) begin
         br_count_d    = '0;
         taken_count_d = '0;
      end else begin
         if (accept)
            br_count_d = br_count_q + 1'b1;
         if (capture)
            taken_count_d = taken_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_count_q    <= '0;
         taken_count_q <= '0;
      end else begin
         br_count_q    <= br_count_d;
         taken_count_q <= taken_count_d;
      end
   end

   assign br_count    = br_count_q;
   assign taken_count = taken_count_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl; stats checks are included when BRANCH_STATS_EN is defined.
module tb_branch_redirect_ctrl;

   localparam int PC_W  = 32;
   localparam int CNT_W = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            br_valid = 1'b0;
   logic            is_branch_taken = 1'b0;
   logic [PC_W-1:0] branch_pc = '0;
   logic            stall_ex = 1'b0;
   logic            imem_ready = 1'b1;
   logic            redirect_valid;
   logic [PC_W-1:0] redirect_pc;
   logic            flush_if;
   logic            flush_id;
   logic            hold_fetch;
   logic            busy;
`ifdef BRANCH_STATS_EN
   logic             stats_clr = 1'b0;
   logic [CNT_W-1:0] br_count;
   logic [CNT_W-1:0] taken_count;
`endif

   int checks   = 0;
   int failures = 0;

   branch_redirect_ctrl #(
      .PC_W(PC_W)
`ifdef BRANCH_STATS_EN
      ,
      .CNT_W(CNT_W)
`endif
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .br_valid(br_valid),
      .is_branch_taken(is_branch_taken),
      .branch_pc(branch_pc),
      .stall_ex(stall_ex),
      .imem_ready(imem_ready),
`ifdef BRANCH_STATS_EN
      .stats_clr(stats_clr),
      .br_count(br_count),
      .taken_count(taken_count),
`endif
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .flush_if(flush_if),
      .flush_id(flush_id),
      .hold_fetch(hold_fetch),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // One cycle of inputs plus the outputs expected in the following cycle.
   typedef struct {
      logic        bv;
      logic        tk;
      logic [31:0] pc;
      logic        st;
      logic        rdy;
      logic        e_rv;
      logic        e_fl;
      logic [31:0] e_pc;
      string       name;
   } vec_t;

   typedef struct {
      logic        rv;
      logic        fl;
      logic [31:0] pc;
      string       name;
   } exp_t;

   vec_t vecs[13];
   exp_t exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
      end
   endtask

   task automatic compare_outputs(input exp_t e);
      chk({e.name, " redirect_valid"}, 32'(redirect_valid), 32'(e.rv));
      chk({e.name, " flush_if"}, 32'(flush_if), 32'(e.fl));
      chk({e.name, " flush_id"}, 32'(flush_id), 32'(e.fl));
      chk({e.name, " hold_fetch"}, 32'(hold_fetch), 32'(e.rv));
      chk({e.name, " busy"}, 32'(busy), 32'(e.rv));
      if (e.rv)
         chk({e.name, " redirect_pc"}, redirect_pc, e.pc);
      $display("txn %s: rv=%0b fl=%0b busy=%0b pc=%08h", e.name, redirect_valid, flush_if, busy, redirect_pc);
   endtask

   // Drive one cycle of inputs, queue the expectation, then compare after the edge.
   task automatic apply(input vec_t v);
      exp_t e;
      br_valid        = v.bv;
      is_branch_taken = v.tk;
      branch_pc       = v.pc;
      stall_ex        = v.st;
      imem_ready      = v.rdy;
      e.rv   = v.e_rv;
      e.fl   = v.e_fl;
      e.pc   = v.e_pc;
      e.name = v.name;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_empty actual=0 expected=1");
      end else begin
         compare_outputs(exp_q.pop_front());
      end
   endtask

   task automatic step(input logic bv, input logic tk, input logic [31:0] pc, input logic rdy, input string nm);
      vec_t v;
      v.bv = bv; v.tk = tk; v.pc = pc; v.st = 1'b0; v.rdy = rdy;
      v.e_rv = 1'b0; v.e_fl = 1'b0; v.e_pc = '0; v.name = nm;
      br_valid = v.bv; is_branch_taken = v.tk; branch_pc = v.pc; stall_ex = v.st; imem_ready = v.rdy;
      @(posedge clk);
      @(negedge clk);
      $display("txn %s: rv=%0b fl=%0b busy=%0b pc=%08h", nm, redirect_valid, flush_if, busy, redirect_pc);
   endtask

   initial begin
      //               bv    tk    pc            st    rdy   e_rv  e_fl  e_pc
      vecs[0]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, "idle"};
      vecs[1]  = '{1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0040, "basic_taken"};
      vecs[2]  = '{1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, "basic_done"};
      vecs[3]  = '{1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, "not_taken"};
      vecs[4]  = '{1'b1, 1'b1, 32'h0000_0080, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0040, "stall_1"};
      vecs[5]  = '{1'b1, 1'b1, 32'h0000_0080, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0040, "stall_2"};
      vecs[6]  = '{1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0080, "unstall_cap"};
      vecs[7]  = '{1'b1, 1'b1, 32'h0000_00C0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0080, "bp_shadow"};
      vecs[8]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0080, "bp_wait_2"};
      vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0080, "bp_wait_3"};
      vecs[10] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0080, "bp_accept"};
      vecs[11] = '{1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0040, "back_to_back"};
      vecs[12] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, "final_idle"};

      // Reset state
      #2;
      chk("reset redirect_valid", 32'(redirect_valid), 32'd0);
      chk("reset flush_if", 32'(flush_if), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset redirect_pc", redirect_pc, 32'd0);
`ifdef BRANCH_STATS_EN
      chk("reset br_count", 32'(br_count), 32'd0);
      chk("reset taken_count", 32'(taken_count), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 13; i++)
         apply(vecs[i]);

`ifdef BRANCH_STATS_EN
      // Accepted in table: basic_taken, not_taken, unstall_cap (stall counted once), back_to_back
      chk("table br_count", 32'(br_count), 32'd4);
      chk("table taken_count", 32'(taken_count), 32'd3);
`endif

      // Asynchronous reset while a redirect is held off by fetch
      step(1'b1, 1'b1, 32'h0000_0200, 1'b0, "rst_cap");
      step(1'b0, 1'b0, 32'h0000_0000, 1'b0, "rst_redirect");
      chk("pre_rst busy", 32'(busy), 32'd1);
      chk("pre_rst redirect_pc", redirect_pc, 32'h0000_0200);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst redirect_valid", 32'(redirect_valid), 32'd0);
      chk("async_rst flush_if", 32'(flush_if), 32'd0);
      chk("async_rst hold_fetch", 32'(hold_fetch), 32'd0);
      chk("async_rst busy", 32'(busy), 32'd0);
      chk("async_rst redirect_pc", redirect_pc, 32'd0);
`ifdef BRANCH_STATS_EN
      chk("async_rst br_count", 32'(br_count), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 1'b0, 32'h0000_0000, 1'b0, "post_rst");
      chk("post_rst busy", 32'(busy), 32'd0);

`ifdef BRANCH_STATS_EN
      // Five accepted branches, three of them taken, then clear alongside an accepted branch
      step(1'b1, 1'b1, 32'h0000_0010, 1'b1, "st_t1");
      step(1'b0, 1'b0, 32'h0000_0000, 1'b1, "st_f1");
      step(1'b1, 1'b0, 32'h0000_0014, 1'b1, "st_n1");
      step(1'b1, 1'b1, 32'h0000_0018, 1'b1, "st_t2");
      step(1'b0, 1'b0, 32'h0000_0000, 1'b1, "st_f2");
      step(1'b1, 1'b0, 32'h0000_001C, 1'b1, "st_n2");
      step(1'b1, 1'b1, 32'h0000_0020, 1'b1, "st_t3");
      step(1'b0, 1'b0, 32'h0000_0000, 1'b1, "st_f3");
      chk("stats br_count", 32'(br_count), 32'd5);
      chk("stats taken_count", 32'(taken_count), 32'd3);
      stats_clr = 1'b1;
      step(1'b1, 1'b0, 32'h0000_0024, 1'b1, "st_clr");
      stats_clr = 1'b0;
      chk("clr br_count", 32'(br_count), 32'd0);
      chk("clr taken_count", 32'(taken_count), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
